// File: rtl/motor_pkg.sv
// motor_pkg: state codes and duty helpers shared by the motor PWM driver.
package motor_pkg;

  // Channel state codes, also reported on statusM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_RUN  = 2'd2,
    ST_DOWN = 2'd3
  } state_e;

  // Full-scale duty for a PWM counter of the given width.
  function automatic int unsigned duty_max(input int unsigned pwm_w);
    return (32'd1 << pwm_w) - 32'd1;
  endfunction

endpackage

// File: rtl/motor_channel.sv
// motor_channel: one motor's FSM with duty ramp, post-request hold timer
// and the registered PWM compare. Ramping (UP/DOWN states and the step
// counter) is built only when SOFT_START_EN is defined.
module motor_channel
  import motor_pkg::*;
#(
  parameter int unsigned PWM_W         = 8,
`ifdef SOFT_START_EN
  parameter int unsigned RAMP_STEP_CYC = 16,
`endif
  parameter int unsigned HOLD_CYC      = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             req,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             move,
  output state_e           state,
  output state_e           state_next
);

  localparam logic [PWM_W-1:0]  DUTY_MAX  = PWM_W'(duty_max(PWM_W));
  localparam logic [PWM_W-1:0]  DUTY_ONE  = PWM_W'(1);
  localparam int unsigned       HOLD_W    = $clog2(HOLD_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  state_e            state_q, state_d;
  logic [PWM_W-1:0]  duty_q, duty_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              move_q, move_d;

`ifdef SOFT_START_EN
  localparam int unsigned       STEP_W    = (RAMP_STEP_CYC > 1) ? $clog2(RAMP_STEP_CYC) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_STEP_CYC - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  logic [STEP_W-1:0] step_q, step_d;
`endif

  // Next-state, duty/hold/step updates and the PWM compare; ena low wins over everything.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    hold_d  = hold_q;
`ifdef SOFT_START_EN
    step_d  = step_q;
`endif
    if (!ena) begin
      move_d = 1'b0;
    end else if (duty_q == DUTY_MAX) begin
      move_d = 1'b1;
    end else begin
      move_d = (pwm_cnt < duty_q);
    end

    if (!ena) begin
      state_d = ST_IDLE;
      duty_d  = '0;
      hold_d  = '0;
`ifdef SOFT_START_EN
      step_d  = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          duty_d = '0;
          if (req) begin
`ifdef SOFT_START_EN
            state_d = ST_UP;
            step_d  = '0;
`else
            state_d = ST_RUN;
            duty_d  = DUTY_MAX;
            hold_d  = HOLD_LOAD;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
`ifdef SOFT_START_EN
        ST_UP: begin
          if (!req) begin
            state_d = ST_DOWN;
            step_d  = '0;
          end else if (step_q == STEP_LAST) begin
            step_d = '0;
            // Saturate at full scale; reaching it hands over to RUN.
            if (duty_q >= DUTY_MAX - DUTY_ONE) begin
              duty_d  = DUTY_MAX;
              state_d = ST_RUN;
              hold_d  = HOLD_LOAD;
            end else begin
              duty_d = duty_q + DUTY_ONE;
            end
          end else begin
            step_d = step_q + STEP_ONE;
          end
        end
        ST_DOWN: begin
          if (req) begin
            state_d = ST_UP;
            step_d  = '0;
          end else if (duty_q == '0) begin
            state_d = ST_IDLE;
            step_d  = '0;
          end else if (step_q == STEP_LAST) begin
            step_d = '0;
            duty_d = duty_q - DUTY_ONE;
            if (duty_q == DUTY_ONE) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DOWN;
            end
          end else begin
            step_d = step_q + STEP_ONE;
          end
        end
`endif
        ST_RUN: begin
          duty_d = DUTY_MAX;
          if (req) begin
            hold_d = HOLD_LOAD;
          end else if (hold_q <= HOLD_ONE) begin
            hold_d = '0;
`ifdef SOFT_START_EN
            state_d = ST_DOWN;
            step_d  = '0;
`else
            state_d = ST_IDLE;
            duty_d  = '0;
`endif
          end else begin
            hold_d = hold_q - HOLD_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = '0;
          hold_d  = '0;
        end
      endcase
    end
  end

  // Channel state, counters and PWM output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      hold_q  <= '0;
      move_q  <= 1'b0;
`ifdef SOFT_START_EN
      step_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      hold_q  <= hold_d;
      move_q  <= move_d;
`ifdef SOFT_START_EN
      step_q  <= step_d;
`endif
    end
  end

  assign move       = move_q;
  assign state      = state_q;
  assign state_next = state_d;

endmodule

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: N_CH soft-start/soft-stop motor drivers sharing one
// free-running PWM counter. Define SOFT_START_EN to build the duty ramps;
// without it channels switch straight between IDLE and RUN.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int unsigned N_CH          = 2,
  parameter int unsigned PWM_W         = 8,
  parameter int unsigned RAMP_STEP_CYC = 16,
  parameter int unsigned HOLD_CYC      = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [N_CH-1:0]   req,
  output logic [N_CH-1:0]   move,
  output logic [2*N_CH-1:0] statusM,
  output logic              busy
);

  // Reject configurations whose timers could never expire.
  if (RAMP_STEP_CYC < 1 || HOLD_CYC < 1) begin : g_bad_cfg
    $error("motor_pwm_driver: RAMP_STEP_CYC and HOLD_CYC must be >= 1");
  end

  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             busy_q, busy_d;
  state_e           ch_state      [N_CH];
  state_e           ch_state_next [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    motor_channel #(
      .PWM_W        (PWM_W),
`ifdef SOFT_START_EN
      .RAMP_STEP_CYC(RAMP_STEP_CYC),
`endif
      .HOLD_CYC     (HOLD_CYC)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .req       (req[i]),
      .pwm_cnt   (pwm_cnt_q),
      .move      (move[i]),
      .state     (ch_state[i]),
      .state_next(ch_state_next[i])
    );
    assign statusM[2*i +: 2] = ch_state[i];
  end

  // Shared PWM counter advance and busy from the channels' next states.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    busy_d    = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      busy_d = busy_d | (ch_state_next[i] != ST_IDLE);
    end
  end

  // PWM counter and busy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb_motor_pwm_driver: directed stimulus with a behavioural channel model
// compared every cycle, plus hand-computed spot values.
module tb_motor_pwm_driver;

  localparam int N_CH = 2;
  localparam int PWM_W = 4;
  localparam int RAMP = 2;
  localparam int HOLD = 5;
  localparam int DMAX = 15;
  localparam int M_IDLE = 0, M_UP = 1, M_RUN = 2, M_DOWN = 3;

`ifdef SOFT_START_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [1:0] req = 2'b11;
  logic [1:0] move;
  logic [3:0] statusM;
  logic       busy;

  always #5 clk = ~clk;

  motor_pwm_driver #(
    .N_CH(N_CH), .PWM_W(PWM_W), .RAMP_STEP_CYC(RAMP), .HOLD_CYC(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req),
    .move(move), .statusM(statusM), .busy(busy)
  );

  int total = 0;
  int bad = 0;

  int m_mode [2];
  int m_duty [2];
  int m_step [2];
  int m_hold [2];
  int m_cnt = 0;
  logic [1:0] exp_move = 2'b00;
  logic [3:0] exp_status = 4'b0000;
  logic       exp_busy = 1'b0;
  bit         chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one channel of the model by one clock, given its request.
  task automatic model_channel(input int ch, input bit r);
    case (m_mode[ch])
      M_IDLE: begin
        if (r) begin
          if (SS) begin
            m_mode[ch] = M_UP; m_step[ch] = 0;
          end else begin
            m_mode[ch] = M_RUN; m_duty[ch] = DMAX; m_hold[ch] = HOLD;
          end
        end
      end
      M_UP: begin
        if (!r) begin
          m_mode[ch] = M_DOWN; m_step[ch] = 0;
        end else begin
          m_step[ch]++;
          if (m_step[ch] == RAMP) begin
            m_step[ch] = 0;
            m_duty[ch] = (m_duty[ch] + 1 > DMAX) ? DMAX : m_duty[ch] + 1;
            if (m_duty[ch] == DMAX) begin
              m_mode[ch] = M_RUN; m_hold[ch] = HOLD;
            end
          end
        end
      end
      M_RUN: begin
        if (r) m_hold[ch] = HOLD;
        else begin
          m_hold[ch]--;
          if (m_hold[ch] <= 0) begin
            m_hold[ch] = 0;
            if (SS) begin
              m_mode[ch] = M_DOWN; m_step[ch] = 0;
            end else begin
              m_mode[ch] = M_IDLE; m_duty[ch] = 0;
            end
          end
        end
      end
      default: begin
        if (r) begin
          m_mode[ch] = M_UP; m_step[ch] = 0;
        end else if (m_duty[ch] == 0) begin
          m_mode[ch] = M_IDLE;
        end else begin
          m_step[ch]++;
          if (m_step[ch] == RAMP) begin
            m_step[ch] = 0;
            m_duty[ch] = (m_duty[ch] - 1 < 0) ? 0 : m_duty[ch] - 1;
            if (m_duty[ch] == 0) m_mode[ch] = M_IDLE;
          end
        end
      end
    endcase
  endtask

  // Model the effect of the coming clock edge using the current inputs.
  task automatic model_edge();
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_mode[c] = M_IDLE; m_duty[c] = 0; m_step[c] = 0; m_hold[c] = 0;
      end
      m_cnt = 0;
      exp_move = 2'b00;
    end else begin
      for (int c = 0; c < 2; c++) begin
        exp_move[c] = (ena && (m_duty[c] == DMAX || m_cnt < m_duty[c])) ? 1'b1 : 1'b0;
        if (!ena) begin
          m_mode[c] = M_IDLE; m_duty[c] = 0; m_step[c] = 0; m_hold[c] = 0;
        end else begin
          model_channel(c, req[c]);
        end
      end
      m_cnt = (m_cnt + 1) % (DMAX + 1);
    end
    exp_status = {2'(m_mode[1]), 2'(m_mode[0])};
    exp_busy = (m_mode[0] != M_IDLE) || (m_mode[1] != M_IDLE);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #4;
  endtask

  // Per-cycle comparison against the model, sampled 2 time units after the edge.
  always @(posedge clk) begin
    #2;
    if (chk_on) begin
      check("cyc_move", 32'(move), 32'(exp_move));
      check("cyc_status", 32'(statusM), 32'(exp_status));
      check("cyc_busy", 32'(busy), 32'(exp_busy));
    end
  end

  initial begin
    int hi;
    for (int c = 0; c < 2; c++) begin
      m_mode[c] = 0; m_duty[c] = 0; m_step[c] = 0; m_hold[c] = 0;
    end
    chk_on = 1'b1;
    #1;

    // Reset with requests and enable asserted.
    rst = 1'b1; ena = 1'b1; req = 2'b11;
    repeat (3) tick();
    check("rst_move", 32'(move), 32'h0);
    check("rst_status", 32'(statusM), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();
    check("start_status", 32'(statusM), SS ? 32'h5 : 32'hA);
    check("start_busy", 32'(busy), 32'h1);

    // Emergency stop right after start.
    ena = 1'b0;
    tick();
    check("estop1_status", 32'(statusM), 32'h0);
    check("estop1_busy", 32'(busy), 32'h0);

    // Channel 0 alone ramps to RUN within 31 clocks.
    ena = 1'b1; req = 2'b01;
    repeat (31) tick();
    check("ramp_run0", 32'(statusM[1:0]), 32'h2);
    check("ramp_idle1", 32'(statusM[3:2]), 32'h0);
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      hi += int'(move[0]);
    end
    check("run_pwm_high", 32'(hi), 32'd16);

    // Hold: request low for 4 clocks keeps RUN, 5th leaves.
    req = 2'b00;
    repeat (4) tick();
    check("hold4_run", 32'(statusM[1:0]), 32'h2);
    tick();
    check("hold5_exit", 32'(statusM[1:0]), SS ? 32'h3 : 32'h0);

    // Back to RUN, then a request pulse restarts the countdown.
    req = 2'b01;
    repeat (6) tick();
    check("rerun", 32'(statusM[1:0]), 32'h2);
    req = 2'b00; repeat (2) tick();
    req = 2'b01; tick();
    req = 2'b00; repeat (4) tick();
    check("pulse_hold_run", 32'(statusM[1:0]), 32'h2);
    tick();
    check("pulse_exit", 32'(statusM[1:0]), SS ? 32'h3 : 32'h0);

    // Ramp down to duty 8, reverse, then fall to IDLE 16 clocks later.
    repeat (14) tick();
    check("down_at8", 32'(statusM[1:0]), SS ? 32'h3 : 32'h0);
    req = 2'b01; tick();
    check("reverse_up", 32'(statusM[1:0]), SS ? 32'h1 : 32'h2);
    req = 2'b00; tick();
    repeat (15) tick();
    check("down_last", 32'(statusM[1:0]), SS ? 32'h3 : 32'h0);
    tick();
    check("down_idle", 32'(statusM[1:0]), 32'h0);
    check("down_busy", 32'(busy), 32'h0);

    // Both channels RUN, then a one-clock emergency stop and restart.
    req = 2'b11;
    repeat (40) tick();
    check("both_run", 32'(statusM), 32'hA);
    ena = 1'b0; tick();
    check("estop2_status", 32'(statusM), 32'h0);
    check("estop2_move", 32'(move), 32'h0);
    check("estop2_busy", 32'(busy), 32'h0);
    ena = 1'b1; tick();
    check("restart_status", 32'(statusM), SS ? 32'h5 : 32'hA);
    check("restart_move", 32'(move), 32'h0);
    tick();
    check("restart_move2", 32'(move), SS ? 32'h0 : 32'h3);

    // Reset in the middle of activity leaves nothing behind.
    repeat (3) tick();
    rst = 1'b1; tick();
    check("midrst_status", 32'(statusM), 32'h0);
    check("midrst_move", 32'(move), 32'h0);
    rst = 1'b0; req = 2'b00; tick();
    check("postrst_status", 32'(statusM), 32'h0);
    check("postrst_move", 32'(move), 32'h0);

    chk_on = 1'b0;
    #20;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
